// File: rtl/dmem_responder.sv
// Data-memory responder for the multicycle RV32I core: one load/store at a time, byte/half/word lanes, optional wait states.
// Build option: define DMEM_ALIGN_CHECK_EN to flag misaligned halfword/word accesses as errors instead of forcing alignment.
module dmem_responder #(
    parameter int unsigned ADDR_WIDTH  = 8,
    parameter int unsigned WAIT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_funct3,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    localparam int unsigned DEPTH     = 2 ** ADDR_WIDTH;
    localparam logic [3:0]  WAIT_LOAD = 4'(WAIT_CYCLES);

    state_t                  state_r;
    state_t                  state_nxt_s;
    logic [3:0]              cnt_r;
    logic                    we_r;
    logic [31:0]             addr_r;
    logic [31:0]             wdata_r;
    logic [2:0]              funct3_r;
    logic                    req_ready_r;
    logic                    rsp_valid_r;
    logic [31:0]             rsp_rdata_r;
    logic                    rsp_err_r;
    logic [31:0]             mem_r [0:DEPTH-1];

    logic                    accept_s;
    logic                    commit_s;
    logic [1:0]              size_s;
    logic [1:0]              off_s;
    logic                    misalign_s;
    logic                    range_err_s;
    logic                    err_s;
    logic [ADDR_WIDTH-1:0]   word_idx_s;
    logic [31:0]             rd_word_s;
    logic [3:0]              lane_en_s;
    logic [31:0]             lane_data_s;
    logic [31:0]             merged_s;
    logic [31:0]             load_val_s;
    logic                    wr_en_s;

    function automatic logic funct3_legal(input logic we, input logic [2:0] f3);
        logic ok;
        if (we) begin
            ok = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010);
        end else begin
            ok = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
                 (f3 == 3'b100) || (f3 == 3'b101);
        end
        return ok;
    endfunction

    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
        logic [3:0] m;
        case (size)
            2'b00:   m = 4'b0001 << off;
            2'b01:   m = 4'b0011 << off;
            2'b10:   m = 4'b1111;
            default: m = 4'b0000;
        endcase
        return m;
    endfunction

    // Replicate the narrow store operand so every candidate lane sees it.
    function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [31:0] wd);
        logic [31:0] d;
        case (size)
            2'b00:   d = {4{wd[7:0]}};
            2'b01:   d = {2{wd[15:0]}};
            default: d = wd;
        endcase
        return d;
    endfunction

    function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] size,
                                                input logic [1:0] off, input logic uns);
        logic [31:0] sh;
        logic [31:0] r;
        sh = word >> {off, 3'b000};
        case (size)
            2'b00:   r = uns ? {24'd0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
            2'b01:   r = uns ? {16'd0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
            2'b10:   r = sh;
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    assign accept_s = req_valid && req_ready_r;
    assign commit_s = (state_r == ST_ACCESS) && (cnt_r == 4'd0);

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_nxt_s = ST_ACCESS;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                if (cnt_r == 4'd0) begin
                    state_nxt_s = ST_RESP;
                end else begin
                    state_nxt_s = ST_ACCESS;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_RESP;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Wait-state down-counter, loaded on accept.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_r <= 4'd0;
        end else if (accept_s) begin
            cnt_r <= WAIT_LOAD;
        end else if ((state_r == ST_ACCESS) && (cnt_r != 4'd0)) begin
            cnt_r <= cnt_r - 4'd1;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Request capture on accept.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            we_r     <= 1'b0;
            addr_r   <= 32'd0;
            wdata_r  <= 32'd0;
            funct3_r <= 3'd0;
        end else if (accept_s) begin
            we_r     <= req_we;
            addr_r   <= req_addr;
            wdata_r  <= req_wdata;
            funct3_r <= req_funct3;
        end else begin
            we_r     <= we_r;
            addr_r   <= addr_r;
            wdata_r  <= wdata_r;
            funct3_r <= funct3_r;
        end
    end

    // Decode of the latched request: legality, lane selection and data alignment.
    always_comb begin
        size_s      = funct3_r[1:0];
        off_s       = addr_r[1:0];
        misalign_s  = 1'b0;
        range_err_s = ((addr_r >> (ADDR_WIDTH + 2)) != 32'd0);
`ifdef DMEM_ALIGN_CHECK_EN
        if (size_s == 2'b01) begin
            misalign_s = addr_r[0];
        end else if (size_s == 2'b10) begin
            misalign_s = (addr_r[1:0] != 2'b00);
        end else begin
            misalign_s = 1'b0;
        end
`else
        if (size_s == 2'b01) begin
            off_s = {addr_r[1], 1'b0};
        end else if (size_s == 2'b10) begin
            off_s = 2'b00;
        end else begin
            off_s = addr_r[1:0];
        end
`endif
        err_s       = !funct3_legal(we_r, funct3_r) || range_err_s || misalign_s;
        word_idx_s  = addr_r[ADDR_WIDTH+1:2];
        rd_word_s   = mem_r[word_idx_s];
        lane_en_s   = lane_mask(size_s, off_s);
        lane_data_s = store_lanes(size_s, wdata_r);
        for (int i = 0; i < 4; i++) begin
            merged_s[8*i +: 8] = lane_en_s[i] ? lane_data_s[8*i +: 8] : rd_word_s[8*i +: 8];
        end
        load_val_s  = load_extend(rd_word_s, size_s, off_s, funct3_r[2]);
        // Gate on reset so a commit edge coinciding with reset cannot write.
        wr_en_s     = commit_s && we_r && !err_s && !reset;
    end

    // RAM write port; contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[word_idx_s] <= merged_s;
        end
    end

    // Registered handshake and response outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req_ready_r <= 1'b1;
            rsp_valid_r <= 1'b0;
            rsp_rdata_r <= 32'd0;
            rsp_err_r   <= 1'b0;
        end else begin
            req_ready_r <= (state_nxt_s == ST_IDLE);
            rsp_valid_r <= (state_nxt_s == ST_RESP);
            if (commit_s) begin
                rsp_rdata_r <= (we_r || err_s) ? 32'd0 : load_val_s;
                rsp_err_r   <= err_s;
            end else if ((state_r == ST_RESP) && rsp_ready) begin
                rsp_rdata_r <= 32'd0;
                rsp_err_r   <= 1'b0;
            end else begin
                rsp_rdata_r <= rsp_rdata_r;
                rsp_err_r   <= rsp_err_r;
            end
        end
    end

    assign req_ready = req_ready_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_rdata = rsp_rdata_r;
    assign rsp_err   = rsp_err_r;

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the multicycle RV32I core. It accepts one load or store request at a time from the core's memory-access state over a valid/ready handshake. It performs byte, halfword or word access on an internal word-organised RAM after a configurable number of wait states. It returns sign- or zero-extended read data, or an error flag, over a second valid/ready handshake.

## Interface
Parameters:
- ADDR_WIDTH, 8: word-address bits; RAM depth is 2**ADDR_WIDTH 32-bit words, byte address range 0 .. 4*2**ADDR_WIDTH-1.
- WAIT_CYCLES, 0: extra cycles spent in ACCESS before the operation commits; legal range 0..15.

Ports:
- clk  input  1  clock; reset reset, asynchronous, active-high; clock clk.
- reset  input  1  asynchronous, active-high reset.
- req_valid  input  1  core presents a request.
- req_ready  output  1  responder can accept; high only in IDLE.
- req_we  input  1  1 = store, 0 = load.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data; the low byte or low halfword is used for SB/SH.
- req_funct3  input  3  RV32I funct3 of the load/store instruction.
- rsp_valid  output  1  response available; high only in RESP.
- rsp_ready  input  1  core accepts the response.
- rsp_rdata  output  32  load result; 0 for stores and on error.
- rsp_err  output  1  request was illegal; no memory side effect.

## Operation
- FSM states and transitions:
  - IDLE to ACCESS on req_valid && req_ready. The request is latched on that edge.
  - ACCESS holds for 1+WAIT_CYCLES cycles, counted by a 4-bit down-counter loaded with WAIT_CYCLES on accept.
  - ACCESS to RESP on the edge where the counter is 0. The memory operation commits on this edge.
  - RESP to IDLE on rsp_ready. Otherwise stay in RESP, holding rsp_rdata and rsp_err stable.
- Legal funct3 values:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Any other value sets rsp_err.
- Range error: if any bit of addr[31:ADDR_WIDTH+2] is nonzero, set rsp_err.
- Alignment error: halfword access with addr[0]=1, or word access with addr[1:0]≠0, sets rsp_err. This check is controlled by the Configuration macro.
- On error, the RAM is not written and rsp_rdata is 0.
- Store: byte-lane write enables are derived from addr[1:0] and size. SB writes lane addr[1:0]; SH writes lanes {addr[1],0} and {addr[1],1}; SW writes all four lanes. Unselected lanes are unchanged.
- Load: the word is read at addr[ADDR_WIDTH+1:2], and the byte or halfword is selected by addr[1:0]. LB/LH sign-extend bit 7/15; LBU/LHU zero-extend.
- RAM contents are not reset. A reset mid-operation aborts the transaction: no write commits unless the commit edge precedes reset assertion.

## Timing
- Reset values: state IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, counter=0.
- Accept on edge E. The operation commits and rsp_valid rises at edge E+1+WAIT_CYCLES.
- Minimum latency is 1 cycle, with WAIT_CYCLES=0.
- req_ready is low from edge E until the edge after the response handshake. Back-to-back throughput is therefore one request per 3+WAIT_CYCLES cycles.
- rsp_rdata and rsp_err are registered and valid whenever rsp_valid=1. Both are driven to 0 in IDLE and ACCESS.
- req_valid during ACCESS or RESP is ignored and not queued.
- Simultaneous events: if rsp_ready is high in the first RESP cycle, RESP lasts exactly one cycle.

## Configuration
- DMEM_ALIGN_CHECK_EN defined: misaligned halfword and word accesses set rsp_err with no side effect.
- DMEM_ALIGN_CHECK_EN undefined: misalignment is never an error.
  - Halfword access forces addr[0]=0.
  - Word access forces addr[1:0]=0.
  - Range and funct3 checks remain active in both builds.

## Test plan
- Word store then load, WAIT_CYCLES=0: SW 0xDEADBEEF at 0x10, then LW 0x10.
  - rsp_valid one cycle after each accept.
  - Load returns 0xDEADBEEF with rsp_err=0.
- Byte and halfword loads after the store above:
  - LB 0x13 returns 0xFFFFFFDE; LBU 0x13 returns 0x000000DE.
  - LH 0x10 returns 0xFFFFBEEF; LHU 0x12 returns 0x0000DEAD.
- Partial store: SB 0x55 at 0x11, then LW 0x10 returns 0xDEAD55EF. SH 0x1234 at 0x12, then LW 0x10 returns 0x123455EF.
- Errors:
  - With DMEM_ALIGN_CHECK_EN: LW 0x11 returns rsp_err=1, rsp_rdata=0.
  - Address 0x400 with ADDR_WIDTH=8: rsp_err=1.
  - funct3=011 store: rsp_err=1, and a follow-up LW of the target word returns the prior value.
- Wait states and backpressure: WAIT_CYCLES=3 with rsp_ready held low for 4 cycles.
  - rsp_valid rises 4 cycles after accept and stays high with stable data.
  - req_ready stays low throughout; a req_valid issued meanwhile is ignored.
- Reset mid-operation: assert reset during ACCESS of an SW with WAIT_CYCLES=2.
  - Outputs return to reset values immediately.
  - The target word is unchanged.
